mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word memory responder with a fixed-latency read pipeline and transaction counters (optional range check: MEM_RESP_RANGE_CHK_EN)
module mem_responder #(
    parameter int MEM_AW     = 16,
    parameter int MEM_DW     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    input  logic              cnt_clr,
    output logic              addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [MEM_DW-1:0]     storage [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [MEM_DW-1:0]     rd_word;

    logic [RD_LAT-1:0]     pipe_vld;
    logic [MEM_DW-1:0]     pipe_data [RD_LAT];
    logic [RD_LAT-1:0]     nxt_vld;
    logic [MEM_DW-1:0]     nxt_data  [RD_LAT];

    assign idx = mem_addr[DEPTH_LOG2-1:0];

`ifdef MEM_RESP_RANGE_CHK_EN
    // Any set bit above the storage index marks the request as out of range.
    assign in_range = ((mem_addr >> DEPTH_LOG2) == '0);
`else
    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr;
    assign in_range = 1'b1;
`endif

    // Requests are only honoured outside reset.
    assign wr_fire = rst_n && mem_req && mem_write;
    assign rd_fire = rst_n && mem_req && !mem_write;

    // Storage is read combinationally so a write from the previous cycle is visible.
    assign rd_word = in_range ? storage[idx] : '0;

    // Storage writes; never reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_fire && in_range) begin
            storage[idx] <= mem_wdata;
        end
    end

    // Next-state view of the read shift register: stage 0 takes the new read.
    always_comb begin
        nxt_vld[0]  = rd_fire;
        nxt_data[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            nxt_vld[i]  = pipe_vld[i-1];
            nxt_data[i] = pipe_data[i-1];
        end
    end

    // Read pipeline advances every cycle; the last stage's data only loads on a valid so it holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld             <= '0;
            pipe_data[RD_LAT-1]  <= '0;
        end else begin
            pipe_vld <= nxt_vld;
            for (int i = 0; i < RD_LAT; i++) begin
                if ((i != RD_LAT - 1) || nxt_vld[i]) begin
                    pipe_data[i] <= nxt_data[i];
                end
            end
        end
    end

    assign mem_rdata_vld = pipe_vld[RD_LAT-1];
    assign mem_rdata     = pipe_data[RD_LAT-1];

    // Saturating transaction counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_fire && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_fire && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

`ifdef MEM_RESP_RANGE_CHK_EN
    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (mem_req && !in_range) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int DL2    = 4;
    localparam int LAT    = 3;
    localparam int DEPTH  = 1 << DL2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          cnt_clr = 1'b0;
    logic          mem_rdata_vld;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;
    logic          addr_err;

    mem_responder #(
        .MEM_AW(AW), .MEM_DW(DW), .DEPTH_LOG2(DL2), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata_vld(mem_rdata_vld),
        .mem_rdata(mem_rdata), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
        .cnt_clr(cnt_clr), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

`ifdef MEM_RESP_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    // Reference model: storage array, queue of pending read returns, counters.
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] m_mem [DEPTH];
    pend_t       m_q[$];
    int          m_rd, m_wr, cyc;
    logic        m_err;
    logic [31:0] m_rdata;
    logic        m_vld;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic req, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic clr, input logic rstn);
        logic inr;
        pend_t p;
        mem_req = req; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        cnt_clr = clr; rst_n = rstn;
        @(posedge clk);
        if (!rstn) begin
            m_q.delete();
            m_rd = 0; m_wr = 0; m_err = 1'b0; m_rdata = '0;
        end else begin
            inr = RANGE_CHK ? (int'(addr) < DEPTH) : 1'b1;
            if (req && !inr) m_err = 1'b1;
            if (req && !wr) begin
                p.due  = cyc + LAT;
                p.data = inr ? m_mem[int'(addr) % DEPTH] : 32'h0;
                m_q.push_back(p);
            end
            if (req && wr && inr) m_mem[int'(addr) % DEPTH] = wd;
            if (clr) begin
                m_rd = 0; m_wr = 0;
            end else if (req) begin
                if (wr) m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
                else    m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
            end
        end
        cyc++;
        #1;
        m_vld = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            m_vld   = 1'b1;
            m_rdata = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk("vld", 32'(mem_rdata_vld), 32'(m_vld));
        chk("rdata", mem_rdata, m_rdata);
        chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        chk("addr_err", 32'(addr_err), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h1, 32'hBAD0_0001, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        req, wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] erd;
        logic [15:0] erc, ewc;
    } vec_t;

    vec_t tbl[5];
    int   nv;

    initial begin
        // Write 0x1234 to 5, read it back one cycle later; with latency 3 the valid shows in cycle 4 only.
        tbl[0] = '{1'b1, 1'b1, 8'd5, 32'h1234, 1'b0, 32'h0,    16'd0, 16'd1};
        tbl[1] = '{1'b1, 1'b0, 8'd5, 32'h0,    1'b0, 32'h0,    16'd1, 16'd1};
        tbl[2] = '{1'b0, 1'b0, 8'd0, 32'h0,    1'b0, 32'h0,    16'd1, 16'd1};
        tbl[3] = '{1'b0, 1'b0, 8'd0, 32'h0,    1'b1, 32'h1234, 16'd1, 16'd1};
        tbl[4] = '{1'b0, 1'b0, 8'd0, 32'h0,    1'b0, 32'h1234, 16'd1, 16'd1};

        cyc = 0;
        do_reset();
        chk("reset_vld", 32'(mem_rdata_vld), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);

        for (int i = 0; i < 5; i++) begin
            step(tbl[i].req, tbl[i].wr, tbl[i].addr, tbl[i].wd, 1'b0, 1'b1);
            chk("tbl_vld", 32'(mem_rdata_vld), 32'(tbl[i].ev));
            chk("tbl_rdata", mem_rdata, tbl[i].erd);
            chk("tbl_rd_cnt", 32'(rd_cnt), 32'(tbl[i].erc));
            chk("tbl_wr_cnt", 32'(wr_cnt), 32'(tbl[i].ewc));
        end

        // Fill every in-range word so later reads are well defined.
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 8'(a), $urandom, 1'b0, 1'b1);

        // Streaming: 8 back-to-back reads must give 8 back-to-back valids in order.
        do_reset();
        for (int a = 0; a < 8; a++) step(1'b1, 1'b1, 8'(a), 32'h100 + 32'(a), 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            if (k < 8) step(1'b1, 1'b0, 8'(k), '0, 1'b0, 1'b1);
            else       idle(1);
            if (k >= 2 && k <= 9) begin
                chk("stream_vld", 32'(mem_rdata_vld), 32'h1);
                chk("stream_data", mem_rdata, 32'h100 + 32'(k - 2));
            end else begin
                chk("stream_gap", 32'(mem_rdata_vld), 32'h0);
            end
        end
        chk("stream_rd_cnt", 32'(rd_cnt), 32'd8);

        // Reset with two reads in flight: neither may ever come back; storage survives.
        step(1'b1, 1'b1, 8'd2, 32'hAAAA_0002, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'd3, 32'hAAAA_0003, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd2, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd3, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd2, '0, 1'b0, 1'b0);
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            idle(1);
            if (mem_rdata_vld === 1'b1) nv++;
        end
        chk("flush_no_vld", 32'(nv), 32'd0);
        step(1'b1, 1'b0, 8'd2, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd3, '0, 1'b0, 1'b1);
        idle(1);
        chk("reread_a2", mem_rdata, 32'hAAAA_0002);
        idle(1);
        chk("reread_a3", mem_rdata, 32'hAAAA_0003);
        idle(2);

        // Range handling on address 0x13.
        step(1'b1, 1'b1, 8'd3, 32'h3333_3333, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h13, 32'hDEAD, 1'b0, 1'b1);
        chk("range_err", 32'(addr_err), RANGE_CHK ? 32'h1 : 32'h0);
        step(1'b1, 1'b0, 8'd3, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h13, '0, 1'b0, 1'b1);
        idle(1);
        chk("range_a3", mem_rdata, RANGE_CHK ? 32'h3333_3333 : 32'hDEAD);
        idle(1);
        chk("range_a13", mem_rdata, RANGE_CHK ? 32'h0 : 32'hDEAD);
        chk("range_a13_vld", 32'(mem_rdata_vld), 32'h1);
        idle(2);

        // Randomized traffic with occasional clears and resets.
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 8'(a), $urandom, 1'b0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) != 0));
        end
        idle(LAT + 1);

        // Write counter saturation, then clear racing a write.
        do_reset();
        for (int k = 0; k < 65540; k++) step(1'b1, 1'b1, 8'(k % DEPTH), 32'(k), 1'b0, 1'b1);
        chk("sat_wr_cnt", 32'(wr_cnt), 32'hFFFF);
        step(1'b1, 1'b1, 8'd0, 32'h5, 1'b1, 1'b1);
        chk("clr_wr_cnt", 32'(wr_cnt), 32'h0);
        step(1'b1, 1'b1, 8'd0, 32'h6, 1'b0, 1'b1);
        chk("post_clr_wr_cnt", 32'(wr_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
